// File: rtl/mig_app_arbiter.sv
// mig_app_arbiter: round-robin share of one MIG app_* UI port between two requesters, with in-order read tag routing
module mig_app_arbiter #(
  parameter int ADDR_W = 29,
  parameter int DATA_W = 128,
  parameter int MAX_RD = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       calib_done,
  input  logic [1:0]                 req_valid,
  input  logic [1:0]                 req_we,
  input  logic [2*ADDR_W-1:0]        req_addr,
  input  logic [2*DATA_W-1:0]        req_wdata,
  output logic [1:0]                 req_ready,
  output logic [1:0]                 rsp_valid,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [ADDR_W-1:0]          app_addr,
  output logic [2:0]                 app_cmd,
  output logic                       app_en,
  input  logic                       app_rdy,
  output logic [DATA_W-1:0]          app_wdf_data,
  output logic                       app_wdf_wren,
  output logic                       app_wdf_end,
  input  logic                       app_wdf_rdy,
  input  logic [DATA_W-1:0]          app_rd_data,
  input  logic                       app_rd_data_valid,
  output logic [$clog2(MAX_RD):0]    rd_outstanding,
  output logic                       err_orphan
);
  localparam int PW = $clog2(MAX_RD);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] MAXC = CW'(MAX_RD);
  typedef enum logic {S_IDLE, S_ISSUE} state_t;
  state_t state_q, state_d;
  logic rr_q, rr_d, id_q, id_d, rd_q, rd_d, en_q, en_d, wren_q, wren_d, orph_q, orph_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rsp_data_q, rsp_data_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] rsp_valid_q, rsp_valid_d, elig;
  logic tags_q [MAX_RD];
  logic grant, gid, push, pop;
  // a read is only eligible while a tag slot is free, so the FIFO can never overflow
  assign elig  = req_valid & (req_we | {2{cnt_q < MAXC}});
  assign grant = (state_q == S_IDLE) && calib_done && |elig;
  assign gid   = &elig ? ~rr_q : elig[1];
  assign push  = en_q & app_rdy & rd_q;
  assign pop   = app_rd_data_valid & |cnt_q;
  always_comb begin
    state_d     = grant ? S_ISSUE
                : (state_q == S_ISSUE && !en_q && !wren_q) ? S_IDLE : state_q;
    rr_d        = grant ? gid : rr_q;
    id_d        = grant ? gid : id_q;
    rd_d        = grant ? ~req_we[gid] : rd_q;
    en_d        = grant | (en_q & ~app_rdy);
    wren_d      = grant ? req_we[gid] : wren_q & ~app_wdf_rdy;
    addr_d      = grant ? (gid ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0]) : addr_q;
    wdata_d     = grant ? (gid ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0]) : wdata_q;
    wp_d        = wp_q + PW'(push);
    rp_d        = rp_q + PW'(pop);
    cnt_d       = cnt_q + CW'(push) - CW'(pop);
    rsp_valid_d = pop ? (tags_q[rp_q] ? 2'b10 : 2'b01) : 2'b00;
    rsp_data_d  = pop ? app_rd_data : rsp_data_q;
    orph_d      = orph_q | (app_rd_data_valid & ~|cnt_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b1;
      id_q        <= 1'b0;
      rd_q        <= 1'b0;
      en_q        <= 1'b0;
      wren_q      <= 1'b0;
      orph_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
      wp_q        <= '0;
      rp_q        <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      id_q        <= id_d;
      rd_q        <= rd_d;
      en_q        <= en_d;
      wren_q      <= wren_d;
      orph_q      <= orph_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      cnt_q       <= cnt_d;
    end
  end
  // tag storage needs no reset: stale entries are unreachable once the pointers clear
  always_ff @(posedge clk) begin
    if (push) tags_q[wp_q] <= id_q;
  end
  // accept pulse is combinational so app_en follows it by one cycle; forced low in reset
  assign req_ready      = (grant && !rst) ? (gid ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign app_addr       = addr_q;
  assign app_cmd        = {2'b00, rd_q};
  assign app_en         = en_q;
  assign app_wdf_data   = wdata_q;
  assign app_wdf_wren   = wren_q;
  assign app_wdf_end    = wren_q;
  assign rd_outstanding = cnt_q;
  assign err_orphan     = orph_q;
endmodule
